// File: rtl/pem_common_param_pkg.sv
// Shared PE-memory types: command, counter-increment and scheduler tracker entry.
package pem_common_param_pkg;

  localparam int PEM_REG_ID_W = 6;
  localparam int PEM_CID_W    = 4;

  typedef struct packed {
    logic [PEM_REG_ID_W-1:0] reg_id;
    logic [PEM_CID_W-1:0]    cid;
  } pem_cmd_t;

  localparam int PEM_CMD_W = $bits(pem_cmd_t);

  typedef struct packed {
    logic inst_inc;
    logic ack_inc;
  } pem_dir_inc_t;

  typedef struct packed {
    pem_dir_inc_t load;
    pem_dir_inc_t store;
  } pem_counter_inc_t;

  localparam int PEM_COUNTER_INC_W = $bits(pem_counter_inc_t);

  typedef enum logic {
    PEM_DIR_LOAD  = 1'b0,
    PEM_DIR_STORE = 1'b1
  } pem_dir_e;

  typedef struct packed {
    logic [PEM_REG_ID_W-1:0] reg_id;
    logic [PEM_CID_W-1:0]    cid;
  } pem_sched_entry_t;

endpackage

// File: rtl/pem_ld_st_sched_if.sv
// Command, dispatch, completion and counter signals of the load/store scheduler.
// master = command/completion source side, slave = scheduler side.
interface pem_ld_st_sched_if;
  import pem_common_param_pkg::*;

  pem_cmd_t         ld_cmd;
  logic             ld_cmd_vld;
  logic             ld_cmd_rdy;
  pem_cmd_t         st_cmd;
  logic             st_cmd_vld;
  logic             st_cmd_rdy;
  pem_cmd_t         eng_cmd;
  logic             eng_cmd_dir;
  logic             eng_cmd_vld;
  logic             eng_cmd_rdy;
  logic             ld_done;
  logic             st_done;
  pem_counter_inc_t pem_counter_inc;
  logic             err_done_underflow;

  modport master (
    output ld_cmd, ld_cmd_vld, st_cmd, st_cmd_vld, eng_cmd_rdy, ld_done, st_done,
    input  ld_cmd_rdy, st_cmd_rdy, eng_cmd, eng_cmd_dir, eng_cmd_vld,
           pem_counter_inc, err_done_underflow
  );

  modport slave (
    input  ld_cmd, ld_cmd_vld, st_cmd, st_cmd_vld, eng_cmd_rdy, ld_done, st_done,
    output ld_cmd_rdy, st_cmd_rdy, eng_cmd, eng_cmd_dir, eng_cmd_vld,
           pem_counter_inc, err_done_underflow
  );

endinterface

// File: rtl/pem_ld_st_tracker.sv
// In-order tracker of dispatched, uncompleted commands for one direction.
// With PEM_LD_ST_HAZARD_CHECK_EN the entries are kept for reg_id/cid matching; otherwise occupancy only.
module pem_ld_st_tracker
  import pem_common_param_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic             push_i,
  input  pem_sched_entry_t push_entry_i,
  input  logic             pop_i,
  input  pem_sched_entry_t query_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             match_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // pop_i is only raised when non-empty, push_i only when not full or popping
  assign cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);

  always_ff @(posedge clk) begin
    if (!s_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

`ifdef PEM_LD_ST_HAZARD_CHECK_EN
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  pem_sched_entry_t mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  ptr_t             wr_ptr_q, rd_ptr_q;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  // Clear before set: when full, a same-cycle push and pop hit the same slot.
  always_comb begin
    vld_d = vld_q;
    if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // NOTE: payload storage has no reset; vld_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i].reg_id == query_i.reg_id || mem_q[i].cid == query_i.cid))
        match_o = 1'b1;
    end
  end
`else
  logic unused_entries;
  assign unused_entries = ^{push_entry_i, query_i};
  assign match_o        = 1'b0;
`endif

endmodule

// File: rtl/pem_ld_st_sched.sv
// Round-robin load/store scheduler into a single registered dispatch slot, with per-direction
// in-flight trackers and counter pulses. Hazard blocking is enabled by PEM_LD_ST_HAZARD_CHECK_EN.
module pem_ld_st_sched
  import pem_common_param_pkg::*;
#(
  parameter int OUTSTANDING_NB = 4
) (
  input logic               clk,
  input logic               s_rst_n,
  pem_ld_st_sched_if.slave  bus
);

  pem_sched_entry_t ld_entry, st_entry;
  logic             ld_full, ld_empty, ld_hit;
  logic             st_full, st_empty, st_hit;
  logic             ld_pop, st_pop, ld_elig, st_elig, slot_free;
  logic             grant_ld, grant_st;

  logic             eng_vld_q, eng_vld_d;
  pem_cmd_t         eng_cmd_q, eng_cmd_d;
  pem_dir_e         eng_dir_q, eng_dir_d;
  pem_dir_e         last_q, last_d;
  pem_counter_inc_t inc_q, inc_d;
  logic             err_q, err_d;

  assign ld_entry = '{reg_id: bus.ld_cmd.reg_id, cid: bus.ld_cmd.cid};
  assign st_entry = '{reg_id: bus.st_cmd.reg_id, cid: bus.st_cmd.cid};

  // Each tracker is queried with the opposite direction's pending command.
  pem_ld_st_tracker #(.DEPTH(OUTSTANDING_NB)) u_ld_trk (
    .clk          (clk),
    .s_rst_n      (s_rst_n),
    .push_i       (grant_ld),
    .push_entry_i (ld_entry),
    .pop_i        (ld_pop),
    .query_i      (st_entry),
    .full_o       (ld_full),
    .empty_o      (ld_empty),
    .match_o      (ld_hit)
  );

  pem_ld_st_tracker #(.DEPTH(OUTSTANDING_NB)) u_st_trk (
    .clk          (clk),
    .s_rst_n      (s_rst_n),
    .push_i       (grant_st),
    .push_entry_i (st_entry),
    .pop_i        (st_pop),
    .query_i      (ld_entry),
    .full_o       (st_full),
    .empty_o      (st_empty),
    .match_o      (st_hit)
  );

  assign ld_pop    = bus.ld_done & ~ld_empty;
  assign st_pop    = bus.st_done & ~st_empty;
  assign ld_elig   = bus.ld_cmd_vld & (~ld_full | ld_pop) & ~st_hit;
  assign st_elig   = bus.st_cmd_vld & (~st_full | st_pop) & ~ld_hit;
  assign slot_free = ~eng_vld_q | bus.eng_cmd_rdy;

  // Grants are gated by reset so both ready outputs read low while reset is held.
  always_comb begin
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (s_rst_n && slot_free) begin
      if (ld_elig && st_elig) begin
        grant_ld = (last_q == PEM_DIR_STORE);
        grant_st = ~grant_ld;
      end else begin
        grant_ld = ld_elig;
        grant_st = st_elig;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    eng_vld_d = eng_vld_q & ~bus.eng_cmd_rdy;
    eng_cmd_d = eng_cmd_q;
    eng_dir_d = eng_dir_q;
    last_d    = last_q;
    if (grant_ld) begin
      eng_vld_d = 1'b1;
      eng_cmd_d = bus.ld_cmd;
      eng_dir_d = PEM_DIR_LOAD;
      last_d    = PEM_DIR_LOAD;
    end else if (grant_st) begin
      eng_vld_d = 1'b1;
      eng_cmd_d = bus.st_cmd;
      eng_dir_d = PEM_DIR_STORE;
      last_d    = PEM_DIR_STORE;
    end
    inc_d                = '0;
    inc_d.load.inst_inc  = grant_ld;
    inc_d.load.ack_inc   = ld_pop;
    inc_d.store.inst_inc = grant_st;
    inc_d.store.ack_inc  = st_pop;
    err_d = err_q | (bus.ld_done & ld_empty) | (bus.st_done & st_empty);
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      eng_vld_q <= 1'b0;
      eng_cmd_q <= '0;
      eng_dir_q <= PEM_DIR_LOAD;
      last_q    <= PEM_DIR_STORE;
      inc_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      eng_vld_q <= eng_vld_d;
      eng_cmd_q <= eng_cmd_d;
      eng_dir_q <= eng_dir_d;
      last_q    <= last_d;
      inc_q     <= inc_d;
      err_q     <= err_d;
    end
  end

  assign bus.ld_cmd_rdy         = grant_ld;
  assign bus.st_cmd_rdy         = grant_st;
  assign bus.eng_cmd_vld        = eng_vld_q;
  assign bus.eng_cmd            = eng_cmd_q;
  assign bus.eng_cmd_dir        = eng_dir_q;
  assign bus.pem_counter_inc    = inc_q;
  assign bus.err_done_underflow = err_q;

endmodule

// File: tb/tb_pem_ld_st_sched.sv
// Bench for pem_ld_st_sched: queue-based reference model checked every cycle plus directed literal checks.
module tb_pem_ld_st_sched;
  import pem_common_param_pkg::*;

  localparam int NB = 4;

`ifdef PEM_LD_ST_HAZARD_CHECK_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic clk;
  logic s_rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  pem_ld_st_sched_if bus ();

  pem_ld_st_sched #(.OUTSTANDING_NB(NB)) dut (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pem_cmd_t mk(input int r, input int c);
    pem_cmd_t v;
    v.reg_id = PEM_REG_ID_W'(r);
    v.cid    = PEM_CID_W'(c);
    return v;
  endfunction

  function automatic pem_counter_inc_t mk_inc(input bit li, input bit la, input bit si, input bit sa);
    pem_counter_inc_t v;
    v.load.inst_inc  = li;
    v.load.ack_inc   = la;
    v.store.inst_inc = si;
    v.store.ack_inc  = sa;
    return v;
  endfunction

  function automatic bit conflicts(input pem_sched_entry_t q[$], input pem_cmd_t c);
    bit hit = 1'b0;
    foreach (q[i]) if (HAZ_EN && (q[i].reg_id == c.reg_id || q[i].cid == c.cid)) hit = 1'b1;
    return hit;
  endfunction

  // Reference model: in-flight queues per direction, the dispatch slot and the last grant.
  pem_sched_entry_t m_ldq[$];
  pem_sched_entry_t m_stq[$];
  bit               m_vld, m_dir, m_last_st, m_err, m_live;
  pem_cmd_t         m_cmd;
  pem_counter_inc_t m_inc;

  initial m_live = 1'b0;

  always @(negedge clk) begin : model
    bit slot_free, ld_ok, st_ok, g_ld, g_st, ld_pop, st_pop;
    ld_pop    = bus.ld_done && (m_ldq.size() != 0);
    st_pop    = bus.st_done && (m_stq.size() != 0);
    slot_free = !m_vld || bus.eng_cmd_rdy;
    ld_ok = bus.ld_cmd_vld && (m_ldq.size() < NB || ld_pop) && !conflicts(m_stq, bus.ld_cmd);
    st_ok = bus.st_cmd_vld && (m_stq.size() < NB || st_pop) && !conflicts(m_ldq, bus.st_cmd);
    g_ld  = s_rst_n && slot_free && ld_ok && (!st_ok || m_last_st);
    g_st  = s_rst_n && slot_free && st_ok && !g_ld;

    if (m_live) begin
      check("m_ld_cmd_rdy", bus.ld_cmd_rdy, g_ld);
      check("m_st_cmd_rdy", bus.st_cmd_rdy, g_st);
      check("m_eng_cmd_vld", bus.eng_cmd_vld, m_vld);
      if (m_vld) begin
        check("m_eng_cmd", bus.eng_cmd, m_cmd);
        check("m_eng_cmd_dir", bus.eng_cmd_dir, m_dir);
      end
      check("m_counter_inc", bus.pem_counter_inc, m_inc);
      check("m_err_underflow", bus.err_done_underflow, m_err);
    end

    if (!s_rst_n) begin
      m_ldq.delete();
      m_stq.delete();
      m_vld     = 1'b0;
      m_dir     = 1'b0;
      m_cmd     = '0;
      m_last_st = 1'b1;
      m_inc     = '0;
      m_err     = 1'b0;
      m_live    = 1'b1;
    end else begin
      m_inc = mk_inc(g_ld, ld_pop, g_st, st_pop);
      m_err = m_err || (bus.ld_done && !ld_pop) || (bus.st_done && !st_pop);
      if (ld_pop) void'(m_ldq.pop_front());
      if (st_pop) void'(m_stq.pop_front());
      if (m_vld && bus.eng_cmd_rdy) m_vld = 1'b0;
      if (g_ld) begin
        m_ldq.push_back('{reg_id: bus.ld_cmd.reg_id, cid: bus.ld_cmd.cid});
        m_vld = 1'b1; m_cmd = bus.ld_cmd; m_dir = 1'b0; m_last_st = 1'b0;
      end
      if (g_st) begin
        m_stq.push_back('{reg_id: bus.st_cmd.reg_id, cid: bus.st_cmd.cid});
        m_vld = 1'b1; m_cmd = bus.st_cmd; m_dir = 1'b1; m_last_st = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ld(input int r, input int c);
    int n = 0;
    bus.ld_cmd     = mk(r, c);
    bus.ld_cmd_vld = 1'b1;
    @(negedge clk);
    while (!bus.ld_cmd_rdy && n < 16) begin
      n++;
      @(negedge clk);
    end
    check("send_ld_granted", bus.ld_cmd_rdy, 1'b1);
    tick();
    bus.ld_cmd_vld = 1'b0;
  endtask

  initial begin
    // Test 1: both directions valid out of reset; first tie goes to load.
    s_rst_n         = 1'b0;
    bus.ld_cmd      = mk(3, 5);
    bus.ld_cmd_vld  = 1'b1;
    bus.st_cmd      = mk(7, 9);
    bus.st_cmd_vld  = 1'b1;
    bus.eng_cmd_rdy = 1'b1;
    bus.ld_done     = 1'b0;
    bus.st_done     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ld_cmd_rdy", bus.ld_cmd_rdy, 1'b0);
    check("rst_st_cmd_rdy", bus.st_cmd_rdy, 1'b0);
    check("rst_eng_cmd_vld", bus.eng_cmd_vld, 1'b0);
    check("rst_eng_cmd", bus.eng_cmd, '0);
    check("rst_eng_cmd_dir", bus.eng_cmd_dir, 1'b0);
    check("rst_counter_inc", bus.pem_counter_inc, '0);
    check("rst_err", bus.err_done_underflow, 1'b0);
    tick();
    s_rst_n = 1'b1;
    @(negedge clk);
    check("t1_tie_ld_rdy", bus.ld_cmd_rdy, 1'b1);
    check("t1_tie_st_rdy", bus.st_cmd_rdy, 1'b0);
    tick();
    bus.ld_cmd_vld = 1'b0;
    @(negedge clk);
    check("t1_ld_disp_vld", bus.eng_cmd_vld, 1'b1);
    check("t1_ld_disp_cmd", bus.eng_cmd, mk(3, 5));
    check("t1_ld_disp_dir", bus.eng_cmd_dir, 1'b0);
    check("t1_ld_inst_inc", bus.pem_counter_inc, mk_inc(1, 0, 0, 0));
    check("t1_st_rdy", bus.st_cmd_rdy, 1'b1);
    tick();
    bus.st_cmd_vld = 1'b0;
    @(negedge clk);
    check("t1_st_disp_cmd", bus.eng_cmd, mk(7, 9));
    check("t1_st_disp_dir", bus.eng_cmd_dir, 1'b1);
    check("t1_st_inst_inc", bus.pem_counter_inc, mk_inc(0, 0, 1, 0));
    tick();
    bus.ld_done = 1'b1;
    bus.st_done = 1'b1;
    tick();
    bus.ld_done = 1'b0;
    bus.st_done = 1'b0;
    @(negedge clk);
    check("t1_ack_incs", bus.pem_counter_inc, mk_inc(0, 1, 0, 1));
    check("t1_no_underflow", bus.err_done_underflow, 1'b0);

    // Test 2: store reg 3 against an in-flight load reg 3.
    tick();
    send_ld(3, 1);
    bus.st_cmd     = mk(3, 2);
    bus.st_cmd_vld = 1'b1;
`ifdef PEM_LD_ST_HAZARD_CHECK_EN
    repeat (3) begin
      @(negedge clk);
      check("t2_st_blocked", bus.st_cmd_rdy, 1'b0);
    end
    tick();
    bus.ld_done = 1'b1;
    @(negedge clk);
    check("t2_same_cycle_pop_blocks", bus.st_cmd_rdy, 1'b0);
    tick();
    bus.ld_done = 1'b0;
    @(negedge clk);
    check("t2_st_granted_after_done", bus.st_cmd_rdy, 1'b1);
    tick();
    bus.st_cmd_vld = 1'b0;
    @(negedge clk);
    check("t2_st_disp_cmd", bus.eng_cmd, mk(3, 2));
    check("t2_st_disp_dir", bus.eng_cmd_dir, 1'b1);
`else
    @(negedge clk);
    check("t2_no_hazard_st_rdy", bus.st_cmd_rdy, 1'b1);
    tick();
    bus.st_cmd_vld = 1'b0;
    bus.ld_done    = 1'b1;
    @(negedge clk);
    check("t2_st_disp_cmd", bus.eng_cmd, mk(3, 2));
`endif
    tick();
    bus.ld_done = 1'b0;
    bus.st_done = 1'b1;
    tick();
    bus.st_done = 1'b0;

    // Test 3: tracker full, then simultaneous pop and push.
    for (int i = 0; i < NB; i++) send_ld(10 + i, i);
    bus.ld_cmd     = mk(14, 4);
    bus.ld_cmd_vld = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t3_full_holdoff", bus.ld_cmd_rdy, 1'b0);
    end
    tick();
    bus.ld_done = 1'b1;
    @(negedge clk);
    check("t3_pop_push_rdy", bus.ld_cmd_rdy, 1'b1);
    tick();
    bus.ld_done = 1'b0;
    bus.ld_cmd  = mk(15, 6);
    @(negedge clk);
    check("t3_inst_and_ack", bus.pem_counter_inc, mk_inc(1, 1, 0, 0));
    check("t3_disp_cmd", bus.eng_cmd, mk(14, 4));
    check("t3_still_full", bus.ld_cmd_rdy, 1'b0);
    tick();
    bus.ld_cmd_vld = 1'b0;
    repeat (NB) begin
      bus.ld_done = 1'b1;
      tick();
    end
    bus.ld_done = 1'b0;

    // Test 4: downstream stall holds the slot; drain grants the opposite direction.
    bus.eng_cmd_rdy = 1'b0;
    send_ld(20, 7);
    bus.st_cmd     = mk(21, 8);
    bus.st_cmd_vld = 1'b1;
    bus.ld_cmd     = mk(22, 9);
    bus.ld_cmd_vld = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_vld", bus.eng_cmd_vld, 1'b1);
      check("t4_stall_cmd", bus.eng_cmd, mk(20, 7));
      check("t4_stall_ld_rdy", bus.ld_cmd_rdy, 1'b0);
      check("t4_stall_st_rdy", bus.st_cmd_rdy, 1'b0);
    end
    tick();
    bus.eng_cmd_rdy = 1'b1;
    @(negedge clk);
    check("t4_drain_st_rdy", bus.st_cmd_rdy, 1'b1);
    check("t4_drain_ld_rdy", bus.ld_cmd_rdy, 1'b0);
    tick();
    bus.st_cmd_vld = 1'b0;
    @(negedge clk);
    check("t4_st_disp_cmd", bus.eng_cmd, mk(21, 8));
    check("t4_ld_rdy_next", bus.ld_cmd_rdy, 1'b1);
    tick();
    bus.ld_cmd_vld = 1'b0;
    @(negedge clk);
    check("t4_ld_disp_cmd", bus.eng_cmd, mk(22, 9));
    tick();
    bus.ld_done = 1'b1;
    bus.st_done = 1'b1;
    tick();
    bus.st_done = 1'b0;
    tick();
    bus.ld_done = 1'b0;

    // Test 5: store done with an empty store tracker.
    tick();
    bus.st_done = 1'b1;
    tick();
    bus.st_done = 1'b0;
    @(negedge clk);
    check("t5_underflow_set", bus.err_done_underflow, 1'b1);
    check("t5_no_st_ack", bus.pem_counter_inc, mk_inc(0, 0, 0, 0));
    repeat (3) tick();
    @(negedge clk);
    check("t5_underflow_sticky", bus.err_done_underflow, 1'b1);

    // Test 6: reset with two loads in flight; same-reg store is granted right after.
    tick();
    send_ld(30, 10);
    send_ld(31, 11);
    bus.st_cmd     = mk(30, 12);
    bus.st_cmd_vld = 1'b1;
    s_rst_n        = 1'b0;
    @(negedge clk);
    check("t6_rdy_in_reset", bus.st_cmd_rdy, 1'b0);
    tick();
    s_rst_n = 1'b1;
    @(negedge clk);
    check("t6_rst_eng_vld", bus.eng_cmd_vld, 1'b0);
    check("t6_rst_eng_cmd", bus.eng_cmd, '0);
    check("t6_rst_inc", bus.pem_counter_inc, '0);
    check("t6_rst_err", bus.err_done_underflow, 1'b0);
    check("t6_st_granted", bus.st_cmd_rdy, 1'b1);
    tick();
    bus.st_cmd_vld = 1'b0;
    @(negedge clk);
    check("t6_st_disp_cmd", bus.eng_cmd, mk(30, 12));
    check("t6_st_disp_dir", bus.eng_cmd_dir, 1'b1);
    check("t6_st_inst_inc", bus.pem_counter_inc, mk_inc(0, 0, 1, 0));
    tick();
    bus.st_done = 1'b1;
    tick();
    bus.st_done = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pem_ld_st_sched.md
# pem_ld_st_sched

Scheduler sharing the PE-memory AXI channel sequencer between load commands (DDR→regfile) and store commands (regfile→DDR). Accepts one `pem_cmd_t` stream per direction. Grants at most one command per cycle into a single registered dispatch slot. Tracks in-flight commands per direction to block reg_id/cid hazards between loads and stores, and produces the `pem_counter_inc_t` pulses used by the instruction-ack counters.

## Interface
- `OUTSTANDING_NB`, 4, maximum in-flight commands per direction; must be ≥1.
- `clk`  in  1  clock.
- `s_rst_n`  in  1  synchronous, active-low reset.
- `ld_cmd`  in  PEM_CMD_W  load command (`pem_cmd_t`: reg_id, cid).
- `ld_cmd_vld` / `ld_cmd_rdy`  in / out  1  load command handshake.
- `st_cmd`  in  PEM_CMD_W  store command.
- `st_cmd_vld` / `st_cmd_rdy`  in / out  1  store command handshake.
- `eng_cmd`  out  PEM_CMD_W  dispatched command.
- `eng_cmd_dir`  out  1  direction: 0 = load, 1 = store.
- `eng_cmd_vld` / `eng_cmd_rdy`  out / in  1  dispatch handshake to the PC channel sequencer.
- `ld_done`  in  1  pulse; oldest in-flight load completed.
- `st_done`  in  1  pulse; oldest in-flight store completed.
- `pem_counter_inc`  out  PEM_COUNTER_INC_W  registered increment pulses.
- `err_done_underflow`  out  1  sticky; a done pulse arrived with its tracker empty.

## Operation
- Each direction has an in-order tracker FIFO of depth OUTSTANDING_NB holding the reg_id and cid of every dispatched, uncompleted command.
  - Push on grant.
  - Pop on the matching done pulse.
- Eligibility, load: `ld_cmd_vld`, load tracker not full, and no store-tracker entry with an equal reg_id or equal cid.
- Eligibility, store: `st_cmd_vld`, store tracker not full, and no load-tracker entry with an equal reg_id or equal cid.
- The dispatch slot accepts a new command when it is empty or draining this cycle (`eng_cmd_vld & eng_cmd_rdy`).
- Arbitration, round-robin:
  - One direction eligible → grant it.
  - Both eligible → grant the direction opposite to the last grant.
  - After reset, the last grant is store, so the first tie goes to load.
- The grant drives `ld_cmd_rdy` or `st_cmd_rdy` high. Never both in the same cycle.
- Hazard comparisons use the tracker state at the start of the cycle. A same-cycle pop does not unblock until the next cycle (conservative).
- Done with a non-empty tracker → pop.
- Done with an empty tracker → no pop, no ack_inc, and `err_done_underflow` is set until reset.
- Grant and done in the same cycle, same direction → push and pop both happen; occupancy is unchanged. Allowed even when the tracker is full, because the pop frees the slot first.
- Width rules: occupancy counters use $clog2(OUTSTANDING_NB+1) bits. Read/write pointers wrap modulo OUTSTANDING_NB.

## Timing
- Input handshake at cycle N → `eng_cmd_vld`, `eng_cmd`, `eng_cmd_dir` valid from N+1 until accepted. Outputs stay stable while `eng_cmd_rdy` is low.
- Sustained throughput: 1 command/cycle when `eng_cmd_rdy` is held high.
- `pem_counter_inc` is a single-cycle pulse:
  - `load.inst_inc` / `store.inst_inc` at N+1 for a grant at N.
  - `load.ack_inc` / `store.ack_inc` at N+1 for a valid done at N.
- Reset values: `eng_cmd_vld`=0, `eng_cmd`=0, `eng_cmd_dir`=0, `ld_cmd_rdy`=0, `st_cmd_rdy`=0, `pem_counter_inc`=0, `err_done_underflow`=0. Trackers are empty.
- Reset mid-operation: all in-flight state is discarded. The downstream sequencer must be reset in the same cycle.

## Configuration
- `PEM_LD_ST_HAZARD_CHECK_EN` defined: reg_id/cid hazard blocking as described above.
- Macro undefined:
  - Eligibility depends only on valid and tracker-not-full.
  - Trackers store only occupancy, not reg_id or cid.
  - Software guarantees ordering.
  - All other behaviour is identical.

## Structure
- Add to `pem_common_param_pkg`:
  - `pem_dir_e` (PEM_DIR_LOAD=0, PEM_DIR_STORE=1).
  - `pem_sched_entry_t` {reg_id, cid}.
- Sub-module `pem_ld_st_tracker`, instantiated once per direction.
  - Contains the FIFO, occupancy counter and full flag.
  - Provides a combinational match output given a query reg_id/cid.

## Test plan
- Load {reg 3, cid 5} and store {reg 7, cid 9} valid from reset, `eng_cmd_rdy`=1 → load dispatched at cycle 1, store at cycle 2; `inst_inc` pulses for load at 1, for store at 2.
- Load reg 3 in flight, then store reg 3 presented → `st_cmd_rdy` stays 0. `ld_done` at cycle N → store granted at N+1, dispatched at N+2.
- OUTSTANDING_NB=4, four loads granted with no done → fifth load held off. `ld_done` with a fifth load presented in the same cycle → pop and push together; occupancy stays 4.
- `eng_cmd_rdy`=0 for 5 cycles with a command in the slot → slot contents stable, both `*_cmd_rdy` low; drains on the first rdy cycle.
- `st_done` pulse while the store tracker is empty → `err_done_underflow`=1 and held; no `store.ack_inc`.
- Reset asserted with 2 loads in flight → all outputs at reset values next cycle; a new store with the same reg_id is granted immediately after reset.
